// File: rtl/multiword_add_sequencer.sv
// Wide add/subtract engine: one NUMBITS carry-lookahead slice is stepped
// LSW-first over NUMWORDS words, carrying through a register between slices.

module nBitCLAdder #(
    parameter int NUMBITS = 8
) (
    input  logic [NUMBITS-1:0] a,
    input  logic [NUMBITS-1:0] b,
    input  logic               c_in,
    output logic [NUMBITS-1:0] s,
    output logic               c_out
);
    localparam int NG = NUMBITS / 4;

    logic [NUMBITS-1:0] g;
    logic [NUMBITS-1:0] p;
    logic [NUMBITS:0]   c;

    assign g    = a & b;
    assign p    = a ^ b;
    assign c[0] = c_in;

    // Full lookahead inside each 4-bit group, groups chained on c[4k].
    for (genvar k = 0; k < NG; k++) begin : g_grp
        localparam int B = 4 * k;
        assign c[B+1] = g[B]
                      | (p[B] & c[B]);
        assign c[B+2] = g[B+1]
                      | (p[B+1] & g[B])
                      | (p[B+1] & p[B] & c[B]);
        assign c[B+3] = g[B+2]
                      | (p[B+2] & g[B+1])
                      | (p[B+2] & p[B+1] & g[B])
                      | (p[B+2] & p[B+1] & p[B] & c[B]);
        assign c[B+4] = g[B+3]
                      | (p[B+3] & g[B+2])
                      | (p[B+3] & p[B+2] & g[B+1])
                      | (p[B+3] & p[B+2] & p[B+1] & g[B])
                      | (p[B+3] & p[B+2] & p[B+1] & p[B] & c[B]);
    end

    assign s     = p ^ c[NUMBITS-1:0];
    assign c_out = c[NUMBITS];
endmodule

module multiword_add_sequencer #(
    parameter int NUMBITS  = 8,
    parameter int NUMWORDS = 4
) (
    input  logic                         clk,
    input  logic                         reset_n,
    input  logic                         in_valid,
    output logic                         in_ready,
    input  logic [NUMBITS*NUMWORDS-1:0]  a_in,
    input  logic [NUMBITS*NUMWORDS-1:0]  b_in,
    input  logic                         sub_in,
    output logic                         out_valid,
    input  logic                         out_ready,
    output logic [NUMBITS*NUMWORDS-1:0]  s_out,
    output logic                         c_out,
    output logic                         ovf_out,
    output logic                         busy
);
    localparam int W    = NUMBITS * NUMWORDS;
    localparam int IDXW = (NUMWORDS > 1) ? $clog2(NUMWORDS) : 1;
    localparam logic [IDXW-1:0] IDX_LAST = IDXW'(NUMWORDS - 1);
    localparam logic [IDXW-1:0] IDX_ONE  = IDXW'(1);

    if ((NUMBITS % 4) != 0 || NUMWORDS < 1) begin : g_bad_param
        $fatal(1, "multiword_add_sequencer: NUMBITS must be a multiple of 4, NUMWORDS >= 1");
    end

    typedef enum logic [1:0] {
        IDLE,
        RUN,
        DONE
    } state_e;

    state_e          state_q, state_d;
    logic [IDXW-1:0] idx_q, idx_d;
    logic            carry_q, carry_d;
    logic [W-1:0]    a_q, a_d;
    logic [W-1:0]    b_q, b_d;
    logic [W-1:0]    s_q, s_d;
    logic            c_q, c_d;
    logic            ovf_q, ovf_d;
    logic            valid_q, valid_d;

    int                 base;
    logic [NUMBITS-1:0] add_a;
    logic [NUMBITS-1:0] add_b;
    logic [NUMBITS-1:0] add_s;
    logic               add_c;

    assign base  = int'(idx_q) * NUMBITS;
    assign add_a = a_q[base +: NUMBITS];
    assign add_b = b_q[base +: NUMBITS];

    nBitCLAdder #(
        .NUMBITS(NUMBITS)
    ) u_adder (
        .a    (add_a),
        .b    (add_b),
        .c_in (carry_q),
        .s    (add_s),
        .c_out(add_c)
    );

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        carry_d = carry_q;
        a_d     = a_q;
        b_d     = b_q;
        s_d     = s_q;
        c_d     = c_q;
        ovf_d   = ovf_q;
        valid_d = valid_q;
        case (state_q)
            IDLE: begin
                if (in_valid) begin
                    // Subtract is A + ~B + 1: invert B once, seed carry.
                    a_d     = a_in;
                    b_d     = b_in ^ {W{sub_in}};
                    carry_d = sub_in;
                    idx_d   = '0;
                    s_d     = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                s_d[base +: NUMBITS] = add_s;
                carry_d = add_c;
                idx_d   = idx_q + IDX_ONE;
                if (idx_q == IDX_LAST) begin
                    c_d     = add_c;
                    ovf_d   = (a_q[W-1] == b_q[W-1])
                            && (add_s[NUMBITS-1] != a_q[W-1]);
                    valid_d = 1'b1;
                    idx_d   = '0;
                    state_d = DONE;
                end
            end
            DONE: begin
                if (out_ready) begin
                    valid_d = 1'b0;
                    state_d = IDLE;
                end
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
            idx_q   <= '0;
            carry_q <= 1'b0;
            a_q     <= '0;
            b_q     <= '0;
            s_q     <= '0;
            c_q     <= 1'b0;
            ovf_q   <= 1'b0;
            valid_q <= 1'b0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            carry_q <= carry_d;
            a_q     <= a_d;
            b_q     <= b_d;
            s_q     <= s_d;
            c_q     <= c_d;
            ovf_q   <= ovf_d;
            valid_q <= valid_d;
        end
    end

    assign in_ready  = (state_q == IDLE);
    assign busy      = (state_q != IDLE);
    assign out_valid = valid_q;
    assign s_out     = s_q;
    assign c_out     = c_q;
    assign ovf_out   = ovf_q;
endmodule

// File: tb/tb_multiword_add_sequencer.sv
// Directed and randomized bench for multiword_add_sequencer over three
// geometries, compared against a plain-arithmetic reference model.

module tb_multiword_add_sequencer;
    logic clk = 1'b0;
    logic reset_n;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic        iv0, ir0, sub0, ov0, or0, c0, f0, bz0;
    logic [31:0] a0, b0, s0;
    logic        iv1, ir1, sub1, ov1, or1, c1, f1, bz1;
    logic [3:0]  a1, b1, s1;
    logic        iv2, ir2, sub2, ov2, or2, c2, f2, bz2;
    logic [31:0] a2, b2, s2;

    multiword_add_sequencer #(.NUMBITS(8), .NUMWORDS(4)) u0 (
        .clk(clk), .reset_n(reset_n), .in_valid(iv0), .in_ready(ir0),
        .a_in(a0), .b_in(b0), .sub_in(sub0), .out_valid(ov0),
        .out_ready(or0), .s_out(s0), .c_out(c0), .ovf_out(f0), .busy(bz0)
    );

    multiword_add_sequencer #(.NUMBITS(4), .NUMWORDS(1)) u1 (
        .clk(clk), .reset_n(reset_n), .in_valid(iv1), .in_ready(ir1),
        .a_in(a1), .b_in(b1), .sub_in(sub1), .out_valid(ov1),
        .out_ready(or1), .s_out(s1), .c_out(c1), .ovf_out(f1), .busy(bz1)
    );

    multiword_add_sequencer #(.NUMBITS(4), .NUMWORDS(8)) u2 (
        .clk(clk), .reset_n(reset_n), .in_valid(iv2), .in_ready(ir2),
        .a_in(a2), .b_in(b2), .sub_in(sub2), .out_valid(ov2),
        .out_ready(or2), .s_out(s2), .c_out(c2), .ovf_out(f2), .busy(bz2)
    );

    // Returns {ovf, carry, sum} for a w-bit add or subtract.
    function automatic logic [33:0] model(input int w, input logic [31:0] a,
                                          input logic [31:0] b, input logic sub);
        longint m, ua, ub, sa, sb, r, t, lo, hi;
        logic [31:0] s;
        logic c, v;
        m  = (longint'(1) << w) - 1;
        ua = longint'(a) & m;
        ub = longint'(b) & m;
        sa = (ua > (m >> 1)) ? ua - (m + 1) : ua;
        sb = (ub > (m >> 1)) ? ub - (m + 1) : ub;
        r  = sub ? ua - ub : ua + ub;
        s  = 32'(r & m);
        c  = sub ? (ua >= ub) : (r > m);
        t  = sub ? sa - sb : sa + sb;
        lo = -((m + 1) >> 1);
        hi = (m >> 1);
        v  = (t < lo) || (t > hi);
        return {v, c, s};
    endfunction

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic op0(input logic [31:0] a, input logic [31:0] b,
                       input logic sub, input int hold);
        logic [33:0] e;
        int lat;
        e = model(32, a, b, sub);
        chk("u0 in_ready idle", ir0, 1);
        a0 = a; b0 = b; sub0 = sub; iv0 = 1;
        step();
        iv0 = 0; a0 = $urandom; b0 = $urandom; sub0 = ~sub;
        lat = 0;
        while (!ov0 && lat < 40) begin
            step();
            lat++;
        end
        chk("u0 latency", lat, 4);
        for (int i = 0; i < hold; i++) begin
            iv0 = 1; a0 = $urandom; b0 = $urandom; sub0 = $urandom;
            step();
            chk("u0 hold out_valid", ov0, 1);
            chk("u0 hold s_out", s0, e[31:0]);
            chk("u0 hold in_ready", ir0, 0);
            chk("u0 hold busy", bz0, 1);
        end
        iv0 = 0;
        chk("u0 s_out", s0, e[31:0]);
        chk("u0 c_out", c0, e[32]);
        chk("u0 ovf_out", f0, e[33]);
        or0 = 1;
        step();
        or0 = 0;
        chk("u0 out_valid drop", ov0, 0);
        chk("u0 in_ready after", ir0, 1);
        chk("u0 busy after", bz0, 0);
    endtask

    task automatic op1(input logic [3:0] a, input logic [3:0] b, input logic sub);
        logic [33:0] e;
        int lat;
        e = model(4, {28'd0, a}, {28'd0, b}, sub);
        a1 = a; b1 = b; sub1 = sub; iv1 = 1;
        step();
        iv1 = 0;
        lat = 0;
        while (!ov1 && lat < 20) begin
            step();
            lat++;
        end
        chk("u1 latency", lat, 1);
        chk("u1 s_out", s1, e[3:0]);
        chk("u1 c_out", c1, e[32]);
        chk("u1 ovf_out", f1, e[33]);
        or1 = 1;
        step();
        or1 = 0;
    endtask

    task automatic op2(input logic [31:0] a, input logic [31:0] b, input logic sub);
        logic [33:0] e;
        int lat;
        e = model(32, a, b, sub);
        a2 = a; b2 = b; sub2 = sub; iv2 = 1;
        step();
        iv2 = 0;
        lat = 0;
        while (!ov2 && lat < 40) begin
            step();
            lat++;
        end
        chk("u2 latency", lat, 8);
        repeat ($urandom_range(0, 3)) step();
        chk("u2 s_out", s2, e[31:0]);
        chk("u2 c_out", c2, e[32]);
        chk("u2 ovf_out", f2, e[33]);
        or2 = 1;
        step();
        or2 = 0;
        chk("u2 out_valid drop", ov2, 0);
    endtask

    initial begin
        reset_n = 0;
        iv0 = 0; or0 = 0; a0 = 0; b0 = 0; sub0 = 0;
        iv1 = 0; or1 = 0; a1 = 0; b1 = 0; sub1 = 0;
        iv2 = 0; or2 = 0; a2 = 0; b2 = 0; sub2 = 0;
        step();
        step();
        chk("reset s_out", s0, 0);
        chk("reset c_out", c0, 0);
        chk("reset ovf_out", f0, 0);
        chk("reset out_valid", ov0, 0);
        chk("reset busy", bz0, 0);
        reset_n = 1;
        step();
        chk("release in_ready", ir0, 1);

        op0(32'hFFFF_FFFF, 32'h0000_0001, 0, 0);
        op0(32'h7FFF_FFFF, 32'h0000_0001, 0, 0);
        op0(32'h0000_0003, 32'h0000_0004, 0, 0);
        op0(32'h0000_0005, 32'h0000_0007, 1, 0);
        op0(32'h8000_0000, 32'h0000_0001, 1, 0);
        op0($urandom, $urandom, 0, 10);

        a0 = 32'hA5A5_A5A5; b0 = 32'h0101_0101; sub0 = 0; iv0 = 1;
        step();
        iv0 = 0;
        step();
        step();
        chk("partial s_out", s0, 32'h0000_A6A6);
        chk("run busy", bz0, 1);
        reset_n = 0;
        #1;
        chk("abort s_out", s0, 0);
        chk("abort c_out", c0, 0);
        chk("abort ovf_out", f0, 0);
        chk("abort out_valid", ov0, 0);
        chk("abort busy", bz0, 0);
        step();
        reset_n = 1;
        step();
        chk("abort in_ready", ir0, 1);
        op0(32'h1234_5678, 32'h1111_1111, 0, 0);

        for (int a = 0; a < 16; a++)
            for (int b = 0; b < 16; b++)
                for (int s = 0; s < 2; s++)
                    op1(4'(a), 4'(b), 1'(s));

        for (int n = 0; n < 1000; n++)
            op2($urandom, $urandom, 1'($urandom));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
